// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - HI/LO multiply/divide sequencer with cancel and stall control
module muldiv_ctrl #(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    localparam logic [2:0] OP_MTHI   = 3'b100;
    localparam logic [2:0] OP_MTLO   = 3'b101;
    localparam logic [5:0] LAST_ITER = 6'(DIV_ITERS - 1);

    state_t      state, stateNext;
    logic [31:0] aReg, bReg, remReg, resHi, resLo;
    logic [5:0]  count;
    logic        isSigned, negQ, negR;

    logic        accept, isMul, isDiv, signedOp;
    logic [31:0] absA, absB, diff;
    logic [32:0] shifted;
    logic        fits;
    logic [63:0] mulA, mulB, product;

    assign accept   = (state == IDLE) && op_valid && !cancel;
    assign isMul    = (op[2:1] == 2'b00);
    assign isDiv    = (op[2:1] == 2'b01);
    assign signedOp = ~op[0];
    assign absA     = (signedOp && src_a[31]) ? -src_a : src_a;
    assign absB     = (signedOp && src_b[31]) ? -src_b : src_b;

    // aReg carries the quotient during divide; remReg:aReg shift left as one pair.
    assign shifted  = {remReg, aReg[31]};
    assign fits     = shifted >= {1'b0, bReg};
    assign diff     = shifted[31:0] - bReg;

    assign mulA     = isSigned ? {{32{aReg[31]}}, aReg} : {32'b0, aReg};
    assign mulB     = isSigned ? {{32{bReg[31]}}, bReg} : {32'b0, bReg};
    assign product  = mulA * mulB;

    always_comb begin
        stateNext = state;
        stall     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept && isMul) begin
                    stall     = 1'b1;
                    stateNext = MUL;
                end else if (accept && isDiv) begin
                    stall     = 1'b1;
                    stateNext = (src_b == 32'b0) ? DONE : DIV;
                end
            end
            MUL: begin
                stall     = 1'b1;
                stateNext = DONE;
            end
            DIV: begin
                stall = 1'b1;
                if (count == LAST_ITER) stateNext = FIX;
            end
            FIX: begin
                stall     = 1'b1;
                stateNext = DONE;
            end
            DONE: begin
                done      = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        if (cancel) begin
            stateNext = IDLE;
            stall     = 1'b0;
            done      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hi       <= 32'b0;
            lo       <= 32'b0;
            count    <= 6'b0;
            aReg     <= 32'b0;
            bReg     <= 32'b0;
            remReg   <= 32'b0;
            resHi    <= 32'b0;
            resLo    <= 32'b0;
            isSigned <= 1'b0;
            negQ     <= 1'b0;
            negR     <= 1'b0;
        end else begin
            state <= stateNext;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (op == OP_MTHI) hi <= src_a;
                        if (op == OP_MTLO) lo <= src_a;
                        isSigned <= signedOp;
                        count    <= 6'b0;
                        remReg   <= 32'b0;
                        if (isMul) begin
                            aReg <= src_a;
                            bReg <= src_b;
                        end else if (isDiv) begin
                            aReg <= absA;
                            bReg <= absB;
                            negQ <= signedOp && (src_a[31] ^ src_b[31]);
                            negR <= signedOp && src_a[31];
                            if (src_b == 32'b0) begin
                                resHi <= src_a;
                                resLo <= '1;
                            end
                        end
                    end
                end
                MUL: {resHi, resLo} <= product;
                DIV: begin
                    count  <= count + 6'd1;
                    aReg   <= {aReg[30:0], fits};
                    remReg <= fits ? diff : shifted[31:0];
                end
                FIX: begin
                    resLo <= negQ ? -aReg : aReg;
                    resHi <= negR ? -remReg : remReg;
                end
                DONE: begin
                    if (!cancel) begin
                        hi <= resHi;
                        lo <= resLo;
                    end
                end
                default: ;
            endcase
            if (cancel && state != IDLE) count <= 6'b0;
        end
    end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - self-checking bench for muldiv_ctrl against an arithmetic model
module tb_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'b0;
    logic [31:0] src_a = 32'b0;
    logic [31:0] src_b = 32'b0;
    logic        cancel = 1'b0;
    logic        stall, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int failures = 0;

    muldiv_ctrl dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
        .src_a(src_a), .src_b(src_b), .cancel(cancel),
        .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Returns {HI, LO} straight from the architectural definition of each op.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] r;
        sa = $signed(a);
        sb = $signed(b);
        r  = 64'b0;
        case (o)
            3'd0: r = sa * sb;
            3'd1: r = {32'b0, a} * {32'b0, b};
            3'd2: r = (b == 0) ? {a, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
            3'd3: r = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            default: r = 64'b0;
        endcase
        return r;
    endfunction

    task automatic doOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int expLat, lat, stallCnt;
        logic [63:0] exp;
        exp    = model(o, a, b);
        expLat = (o[1] == 1'b0) ? 2 : ((b == 0) ? 1 : 34);
        @(negedge clk);
        op_valid = 1'b1; op = o; src_a = a; src_b = b;
        #1;
        lat = -1;
        stallCnt = 0;
        for (int c = 0; c < 60 && lat < 0; c++) begin
            if (stall) stallCnt++;
            if (done) lat = c;
            else begin
                @(negedge clk);
                op_valid = 1'b0; op = 3'($urandom); src_a = $urandom; src_b = $urandom;
                #1;
            end
        end
        check($sformatf("op%0d_latency", o), 64'(lat), 64'(expLat));
        check($sformatf("op%0d_stall_cycles", o), 64'(stallCnt), 64'(expLat));
        @(negedge clk);
        #1;
        check($sformatf("op%0d_done_once", o), 64'(done), 64'd0);
        check($sformatf("op%0d_hilo a=%h b=%h", o, a, b), {hi, lo}, exp);
    endtask

    task automatic mtPair(input logic [31:0] h, input logic [31:0] l);
        @(negedge clk);
        op_valid = 1'b1; op = 3'b100; src_a = h; src_b = $urandom;
        #1;
        check("mthi_stall", 64'(stall), 64'd0);
        check("mthi_done", 64'(done), 64'd0);
        @(negedge clk);
        op = 3'b101; src_a = l;
        #1;
        check("mthi_hi", 64'(hi), 64'(h));
        check("mtlo_stall", 64'(stall), 64'd0);
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        check("mtlo_lo", 64'(lo), 64'(l));
        check("mtlo_done", 64'(done), 64'd0);
    endtask

    initial begin
        int doneSeen;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_stall", 64'(stall), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);

        doOp(3'd0, 32'hFFFFFFFF, 32'h2);
        doOp(3'd1, 32'hFFFFFFFF, 32'h2);
        doOp(3'd2, 32'hFFFFFFF9, 32'h2);
        doOp(3'd3, 32'd100, 32'd7);
        doOp(3'd2, 32'h80000000, 32'hFFFFFFFF);
        doOp(3'd3, 32'd5, 32'd0);
        doOp(3'd2, 32'h7FFFFFFF, 32'h80000000);
        doOp(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);

        mtPair(32'h12345678, 32'hCAFEBABE);

        for (int i = 0; i < 16; i++) begin
            ro = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 5) == 0) rb = 32'b0;
            else if ($urandom_range(0, 2) == 0) rb = 32'($urandom_range(1, 300));
            doOp(ro, ra, rb);
        end

        // Cancel mid-divide: no commit, stall drops immediately.
        mtPair(32'hAA, 32'hBB);
        @(negedge clk);
        op_valid = 1'b1; op = 3'b010; src_a = 32'd1000; src_b = 32'd3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            op_valid = 1'b0;
        end
        #1;
        check("cancel_div_stall_before", 64'(stall), 64'd1);
        cancel = 1'b1;
        #1;
        check("cancel_div_stall", 64'(stall), 64'd0);
        check("cancel_div_done", 64'(done), 64'd0);
        @(negedge clk);
        cancel = 1'b0;
        #1;
        check("cancel_div_idle_stall", 64'(stall), 64'd0);
        doneSeen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (done) doneSeen++;
        end
        check("cancel_div_no_done", 64'(doneSeen), 64'd0);
        check("cancel_div_hilo", {hi, lo}, {32'hAA, 32'hBB});

        // Cancel in the commit cycle.
        @(negedge clk);
        op_valid = 1'b1; op = 3'b001; src_a = 32'd7; src_b = 32'd9;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        #1;
        check("cancel_done_pre", 64'(done), 64'd1);
        cancel = 1'b1;
        #1;
        check("cancel_done_done", 64'(done), 64'd0);
        check("cancel_done_stall", 64'(stall), 64'd0);
        @(negedge clk);
        cancel = 1'b0;
        #1;
        check("cancel_done_hilo", {hi, lo}, {32'hAA, 32'hBB});

        // Cancel coinciding with MTHI suppresses the write.
        @(negedge clk);
        op_valid = 1'b1; op = 3'b100; src_a = 32'hDEAD; cancel = 1'b1;
        @(negedge clk);
        op_valid = 1'b0; cancel = 1'b0;
        #1;
        check("cancel_mthi_hi", 64'(hi), 64'hAA);

        // Reset during MUL.
        @(negedge clk);
        op_valid = 1'b1; op = 3'b000; src_a = 32'd50; src_b = 32'd60;
        @(negedge clk);
        op_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mul_stall", 64'(stall), 64'd0);
        check("rst_mul_done", 64'(done), 64'd0);
        check("rst_mul_hilo", {hi, lo}, 64'd0);
        doOp(3'd0, 32'd3, 32'd4);
        check("post_rst_lo12", 64'(lo), 64'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
